// File: rtl/enc_frame_serializer.sv
// enc_frame_serializer
//   Takes 78-bit words from the encryption stage and sends each one out on a
//   single serial line as a frame of 80 bit periods:
//     - 78 data bits, MSB first
//     - 1 even-parity bit (XOR of the 78 data bits)
//     - 1 gap bit at idle level 1
//   Each bit is held for CLKS_PER_BIT clock cycles. All outputs are registered.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (1..255)
//
// Ports
//   Clk          system clock; all state updates on its rising edge
//   Rst          synchronous active-high reset; wins over enc_valid
//   enc_valid    upstream word present on enc_data
//   enc_data     78-bit encrypted word
//   enc_ready    a word offered this cycle will be accepted
//   tx_bit       serial line (idle 1)
//   tx_valid     one-cycle strobe on the first cycle of each transmitted bit
//   tx_sof       flags the strobe of the first data bit of a frame
//   tx_eof       flags the strobe of the parity bit
//   busy         frame in progress (inverse of enc_ready)
//   frame_count  frames accepted since reset, modulo 256
module enc_frame_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        enc_valid,
  input  logic [77:0] enc_data,
  output logic        enc_ready,
  output logic        tx_bit,
  output logic        tx_valid,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic        busy,
  output logic [7:0]  frame_count
);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [6:0] BIT_LAST = 7'd77;

  // state_q always describes what is currently on the registered outputs.
  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [6:0]  bit_q, bit_d;
  // Holds the data bits not yet driven; bit 77 goes straight to tx_bit on
  // acceptance, so only the remaining 77 bits need storing.
  logic [76:0] shreg_q, shreg_d;
  logic        par_q, par_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        ready_q, ready_d;
  logic        tx_bit_q, tx_bit_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_sof_q, tx_sof_d;
  logic        tx_eof_q, tx_eof_d;

  logic div_wrap;
  logic accept;

  assign div_wrap = (div_q == DIV_LAST);
  // ready_q is high in IDLE and in the final cycle of GAP, which lets a new
  // frame start immediately after the gap with no idle cycle in between.
  assign accept   = ready_q & enc_valid;

  always_comb begin
    state_d    = state_q;
    div_d      = div_wrap ? 8'd0 : div_q + 8'd1;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    fcnt_d     = fcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_valid_d = 1'b0;
    tx_sof_d   = 1'b0;
    tx_eof_d   = 1'b0;

    case (state_q)
      IDLE: begin
        div_d    = 8'd0;
        tx_bit_d = 1'b1;
      end
      SHIFT: begin
        if (div_wrap) begin
          tx_valid_d = 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d  = PARITY;
            bit_d    = 7'd0;
            tx_bit_d = par_q;
            tx_eof_d = 1'b1;
          end else begin
            bit_d    = bit_q + 7'd1;
            shreg_d  = {shreg_q[75:0], 1'b0};
            tx_bit_d = shreg_q[76];
          end
        end
      end
      PARITY: begin
        if (div_wrap) begin
          state_d  = GAP;
          tx_bit_d = 1'b1;
        end
      end
      GAP: begin
        if (div_wrap) begin
          state_d  = IDLE;
          div_d    = 8'd0;
          tx_bit_d = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        div_d    = 8'd0;
        tx_bit_d = 1'b1;
      end
    endcase

    // Acceptance overrides both IDLE and the last GAP cycle.
    if (accept) begin
      state_d    = SHIFT;
      div_d      = 8'd0;
      bit_d      = 7'd0;
      shreg_d    = enc_data[76:0];
      par_d      = ^enc_data;
      fcnt_d     = fcnt_q + 8'd1;
      tx_bit_d   = enc_data[77];
      tx_valid_d = 1'b1;
      tx_sof_d   = 1'b1;
    end

    ready_d = (state_d == IDLE) || ((state_d == GAP) && (div_d == DIV_LAST));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      div_q      <= 8'd0;
      bit_q      <= 7'd0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      fcnt_q     <= 8'd0;
      ready_q    <= 1'b1;
      tx_bit_q   <= 1'b1;
      tx_valid_q <= 1'b0;
      tx_sof_q   <= 1'b0;
      tx_eof_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      fcnt_q     <= fcnt_d;
      ready_q    <= ready_d;
      tx_bit_q   <= tx_bit_d;
      tx_valid_q <= tx_valid_d;
      tx_sof_q   <= tx_sof_d;
      tx_eof_q   <= tx_eof_d;
    end
  end

  assign enc_ready   = ready_q;
  assign busy        = ~ready_q;
  assign tx_bit      = tx_bit_q;
  assign tx_valid    = tx_valid_q;
  assign tx_sof      = tx_sof_q;
  assign tx_eof      = tx_eof_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_enc_frame_serializer.sv
// Bench for enc_frame_serializer. Two instances share one clock: index 0 runs
// with CLKS_PER_BIT=4, index 1 with CLKS_PER_BIT=1. Expected frames
// {data, parity} are queued when a word is offered; a line monitor rebuilds
// each frame from tx_bit/tx_valid and compares it against the queue head.
module tb_enc_frame_serializer;

  logic        Clk = 1'b0;
  logic [1:0]  rst_w, valid_w, ready_w, bit_w, txv_w, sof_w, eof_w, busy_w;
  logic [77:0] data_w [2];
  logic [7:0]  fc_w [2];

  int vectors = 0;
  int miscompares = 0;

  // Monitor state, indexed by instance
  logic        act [2];
  int          bcnt [2];
  int          plen [2];
  logic        unst [2];
  logic        lastb [2];
  logic [77:0] cur [2];
  int          done [2];
  int          eofs [2];
  int          vcnt [2];
  int          exp_done [2];

  logic [78:0] q0 [$];
  logic [78:0] q1 [$];

  always #5 Clk = ~Clk;

  enc_frame_serializer #(.CLKS_PER_BIT(4)) dut4 (
    .Clk(Clk), .Rst(rst_w[0]), .enc_valid(valid_w[0]), .enc_data(data_w[0]),
    .enc_ready(ready_w[0]), .tx_bit(bit_w[0]), .tx_valid(txv_w[0]),
    .tx_sof(sof_w[0]), .tx_eof(eof_w[0]), .busy(busy_w[0]), .frame_count(fc_w[0])
  );

  enc_frame_serializer #(.CLKS_PER_BIT(1)) dut1 (
    .Clk(Clk), .Rst(rst_w[1]), .enc_valid(valid_w[1]), .enc_data(data_w[1]),
    .enc_ready(ready_w[1]), .tx_bit(bit_w[1]), .tx_valid(txv_w[1]),
    .tx_sof(sof_w[1]), .tx_eof(eof_w[1]), .busy(busy_w[1]), .frame_count(fc_w[1])
  );

  function automatic int cpb(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input logic [78:0] v);
    if (d == 0) q0.push_back(v);
    else q1.push_back(v);
    exp_done[d]++;
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [78:0] qpop(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Rebuilds frames from the serial line, sampled 1 time unit after each edge.
  task automatic mon_step(input int d);
    logic [78:0] e;
    if (rst_w[d]) begin
      act[d]  = 1'b0;
      plen[d] = 0;
    end else begin
      plen[d]++;
      if (act[d] && !txv_w[d] && (bit_w[d] !== lastb[d])) unst[d] = 1'b1;
      if (txv_w[d]) begin
        vcnt[d]++;
        if (eof_w[d]) eofs[d]++;
        if (act[d]) begin
          chk("bit_hold_len", 80'(plen[d]), 80'(cpb(d)));
          chk("bit_hold_stable", 80'(unst[d]), 80'd0);
          chk("sof_mid_frame", 80'(sof_w[d]), 80'd0);
        end
        if (sof_w[d]) begin
          act[d]  = 1'b1;
          bcnt[d] = 0;
          cur[d]  = '0;
        end
        plen[d]  = 0;
        unst[d]  = 1'b0;
        lastb[d] = bit_w[d];
        if (act[d]) begin
          if (bcnt[d] < 78) begin
            cur[d] = {cur[d][76:0], bit_w[d]};
            chk("eof_on_data", 80'(eof_w[d]), 80'd0);
            bcnt[d]++;
          end else begin
            chk("eof_on_parity", 80'(eof_w[d]), 80'd1);
            chk("sb_nonempty", 80'(qsize(d) > 0), 80'd1);
            if (qsize(d) > 0) begin
              e = qpop(d);
              chk("frame_content", 80'({cur[d], bit_w[d]}), 80'(e));
            end
            act[d] = 1'b0;
            done[d]++;
          end
        end
      end
    end
  endtask

  always @(posedge Clk) begin
    #1;
    mon_step(0);
    mon_step(1);
  end

  task automatic pulse_rst(input int d);
    rst_w[d] = 1'b1;
    @(negedge Clk);
    rst_w[d] = 1'b0;
  endtask

  // Advances n (negedges since acceptance) until enc_ready is seen, bounded.
  task automatic wait_ready(input int d, inout int n);
    while (!ready_w[d] && n < 4000) begin
      @(negedge Clk);
      n++;
    end
  endtask

  // Offers w for one cycle; returns at the first negedge after acceptance.
  task automatic accept_word(input int d, input logic [77:0] w, input bit expect_it);
    int k;
    k = 0;
    while (!ready_w[d] && k < 4000) begin
      @(negedge Clk);
      k++;
    end
    chk("ready_before_send", 80'(ready_w[d]), 80'd1);
    data_w[d]  = w;
    valid_w[d] = 1'b1;
    if (expect_it) push(d, {w, ^w});
    @(negedge Clk);
    valid_w[d] = 1'b0;
    data_w[d]  = ~w;
  endtask

  task automatic run_frame(input int d, input logic [77:0] w);
    int n;
    accept_word(d, w, 1'b1);
    chk("first_strobe_valid", 80'(txv_w[d]), 80'd1);
    chk("first_strobe_sof", 80'(sof_w[d]), 80'd1);
    chk("first_strobe_bit", 80'(bit_w[d]), 80'(w[77]));
    chk("busy_in_frame", 80'(busy_w[d]), 80'd1);
    n = 1;
    wait_ready(d, n);
    chk("frame_period", 80'(n), 80'(80 * cpb(d)));
  endtask

  // enc_valid held high across cnt words; each must be taken the cycle
  // enc_ready rises, giving contiguous frames.
  task automatic burst(input int d, input int cnt);
    int n;
    logic [95:0] r;
    logic [77:0] w;
    for (int i = 0; i < cnt; i++) begin
      r = {$urandom(), $urandom(), $urandom()};
      w = r[77:0];
      chk("burst_ready", 80'(ready_w[d]), 80'd1);
      chk("burst_fc", 80'(fc_w[d]), 80'(i % 256));
      data_w[d]  = w;
      valid_w[d] = 1'b1;
      push(d, {w, ^w});
      @(negedge Clk);
      n = 1;
      wait_ready(d, n);
      chk("burst_period", 80'(n), 80'(80 * cpb(d)));
    end
    valid_w[d] = 1'b0;
  endtask

  initial begin
    int n;
    int e0;
    int v0;
    logic [77:0] w;
    logic [95:0] r;

    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0; bcnt[d] = 0; plen[d] = 0; unst[d] = 1'b0; lastb[d] = 1'b1;
      cur[d] = '0; done[d] = 0; eofs[d] = 0; vcnt[d] = 0; exp_done[d] = 0;
      data_w[d] = '0;
    end
    rst_w   = 2'b11;
    valid_w = 2'b00;
    repeat (3) @(negedge Clk);
    rst_w = 2'b00;

    // Reset state of both instances
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 80'(ready_w[d]), 80'd1);
      chk("rst_busy", 80'(busy_w[d]), 80'd0);
      chk("rst_tx_bit", 80'(bit_w[d]), 80'd1);
      chk("rst_tx_valid", 80'(txv_w[d]), 80'd0);
      chk("rst_sof", 80'(sof_w[d]), 80'd0);
      chk("rst_eof", 80'(eof_w[d]), 80'd0);
      chk("rst_fc", 80'(fc_w[d]), 80'd0);
    end

    // Single-bit word: 77 zeros, a one, parity one
    run_frame(0, 78'h1);
    chk("fc_after_one", 80'(fc_w[0]), 80'd1);
    chk("done_after_one", 80'(done[0]), 80'(exp_done[0]));

    // All ones and all zeros, both even parity 0
    run_frame(0, {78{1'b1}});
    run_frame(0, 78'h0);
    chk("fc_after_three", 80'(fc_w[0]), 80'd3);
    chk("done_after_three", 80'(done[0]), 80'(exp_done[0]));

    // Three words with enc_valid held high
    pulse_rst(0);
    burst(0, 3);
    repeat (5) @(negedge Clk);
    chk("burst3_fc", 80'(fc_w[0]), 80'd3);
    chk("burst3_done", 80'(done[0]), 80'(exp_done[0]));
    chk("burst3_queue_empty", 80'(qsize(0)), 80'd0);

    // enc_valid pulses during SHIFT and GAP are ignored
    pulse_rst(0);
    w = 78'h2A_5555_AAAA_1234_5678;
    accept_word(0, w, 1'b1);
    n = 1;
    while (!ready_w[0] && n < 4000) begin
      @(negedge Clk);
      n++;
      if (n == 50 || n == 318) begin
        data_w[0]  = ~w;
        valid_w[0] = 1'b1;
      end else begin
        valid_w[0] = 1'b0;
      end
    end
    valid_w[0] = 1'b0;
    chk("ignore_period", 80'(n), 80'd320);
    repeat (20) @(negedge Clk);
    chk("ignore_fc", 80'(fc_w[0]), 80'd1);
    chk("ignore_done", 80'(done[0]), 80'(exp_done[0]));
    chk("ignore_queue_empty", 80'(qsize(0)), 80'd0);
    chk("ignore_idle_valid", 80'(txv_w[0]), 80'd0);

    // Reset during bit 40 aborts the frame
    e0 = eofs[0];
    accept_word(0, 78'h3F_0F0F_F0F0_0F0F_F0F0, 1'b0);
    n = 1;
    while (n < 162) begin
      @(negedge Clk);
      n++;
    end
    rst_w[0] = 1'b1;
    @(negedge Clk);
    rst_w[0] = 1'b0;
    chk("abort_tx_bit", 80'(bit_w[0]), 80'd1);
    chk("abort_ready", 80'(ready_w[0]), 80'd1);
    chk("abort_fc", 80'(fc_w[0]), 80'd0);
    chk("abort_tx_valid", 80'(txv_w[0]), 80'd0);
    repeat (400) @(negedge Clk);
    chk("abort_no_eof", 80'(eofs[0]), 80'(e0));
    chk("abort_done", 80'(done[0]), 80'(exp_done[0]));
    run_frame(0, 78'h1C_DEAD_BEEF_CAFE_F00D);
    chk("after_abort_fc", 80'(fc_w[0]), 80'd1);

    // Reset and enc_valid together: reset wins
    rst_w[0]   = 1'b1;
    valid_w[0] = 1'b1;
    data_w[0]  = 78'h15_0000_1111_2222_3333;
    @(negedge Clk);
    rst_w[0]   = 1'b0;
    valid_w[0] = 1'b0;
    chk("rst_win_ready", 80'(ready_w[0]), 80'd1);
    chk("rst_win_fc", 80'(fc_w[0]), 80'd0);
    chk("rst_win_valid", 80'(txv_w[0]), 80'd0);
    repeat (20) @(negedge Clk);
    chk("rst_win_done", 80'(done[0]), 80'(exp_done[0]));
    chk("rst_win_fc_later", 80'(fc_w[0]), 80'd0);

    // CLKS_PER_BIT=1: single frame, then 256 back-to-back frames
    r = {$urandom(), $urandom(), $urandom()};
    run_frame(1, r[77:0]);
    pulse_rst(1);
    v0 = vcnt[1];
    burst(1, 256);
    repeat (5) @(negedge Clk);
    chk("wrap_fc", 80'(fc_w[1]), 80'd0);
    chk("wrap_strobes", 80'(vcnt[1] - v0), 80'(256 * 79));
    chk("wrap_done", 80'(done[1]), 80'(exp_done[1]));
    chk("wrap_queue_empty", 80'(qsize(1)), 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/enc_frame_serializer.md
ENC_FRAME_SERIALIZER -- requirements
Module: enc_frame_serializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, meaning clock cycles each serial bit is held; legal range 1..255.
REQ-002 Clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 Rst  input  1  reset, synchronous and active-high.
REQ-004 enc_valid  input  1  upstream encrypter word is present on enc_data.
REQ-005 enc_data  input  78  encrypted word from the encryption stage.
REQ-006 enc_ready  output  1  block can accept a word this cycle.
REQ-007 tx_bit  output  1  serial line; idle level 1.
REQ-008 tx_valid  output  1  one-cycle strobe on the first cycle of each transmitted bit.
REQ-009 tx_sof  output  1  high with tx_valid of the first data bit of a frame.
REQ-010 tx_eof  output  1  high with tx_valid of the parity bit.
REQ-011 busy  output  1  frame in progress (inverse of enc_ready).
REQ-012 frame_count  output  8  number of frames accepted since reset, modulo 256.

Function
REQ-013 Frame SHALL be 78 data bits MSB first (enc_data[77] first), then 1 even-parity bit (XOR of all 78 bits), then 1 gap bit at level 1: 80 bit periods total.
REQ-014 States SHALL be IDLE, SHIFT, PARITY, GAP.
REQ-015 IDLE: enc_ready=1, tx_bit=1, tx_valid=0; on enc_valid=1 SHALL capture enc_data into a 78-bit shift register, compute and store parity, increment frame_count, go to SHIFT.
REQ-016 All outputs SHALL be registered; first data bit with tx_valid=1 and tx_sof=1 SHALL appear the cycle after the acceptance edge.
REQ-017 A divider counter SHALL count 0..CLKS_PER_BIT-1 per bit; tx_valid=1 only when divider=0; tx_bit stable for the full bit period.
REQ-018 SHIFT: a bit counter 0..77 SHALL advance on divider wrap; shift register shifts left by one; after bit 77's period, go to PARITY.
REQ-019 PARITY: tx_bit=stored parity for one bit period, tx_eof=1 with its tx_valid; then go to GAP.
REQ-020 GAP: tx_bit=1, tx_valid=0 for one bit period; then go to IDLE.
REQ-021 enc_ready SHALL return to 1 exactly 80*CLKS_PER_BIT cycles after the acceptance cycle; back-to-back words SHALL be accepted with no additional idle cycles.
REQ-022 enc_valid while busy=1 SHALL be ignored; no data captured, no counter change; upstream holds the word until enc_ready=1.
REQ-023 frame_count SHALL wrap 255 -> 0 without affecting transmission.
REQ-024 CLKS_PER_BIT=1: tx_valid SHALL be high every cycle of SHIFT and PARITY; frame occupies 80 cycles.
REQ-025 enc_data changes after acceptance SHALL not affect the frame in flight.

Reset
REQ-026 Rst=1 at a rising edge SHALL force IDLE, enc_ready=1, busy=0, tx_bit=1, tx_valid=0, tx_sof=0, tx_eof=0, frame_count=0, all internal counters 0.
REQ-027 Rst mid-frame SHALL abort the frame immediately; no further data, parity or eof is emitted.
REQ-028 Rst and enc_valid in the same cycle: reset SHALL win; word not accepted.

Verification
REQ-029 CLKS_PER_BIT=4, enc_data=78'h1, enc_valid one cycle -> 77 zero bits then 1, parity bit 1, tx_sof on first strobe, tx_eof on 79th strobe, enc_ready high 320 cycles after accept, frame_count=1.
REQ-030 enc_data=all 78 ones -> 78 ones on tx_bit, parity 0; enc_data=0 -> 78 zeros, parity 0; each bit held exactly 4 cycles.
REQ-031 enc_valid held high continuously with 3 different words -> three contiguous 80-bit-period frames, each word captured once, frame_count=3.
REQ-032 Rst asserted during bit 40 of a frame -> next cycle tx_bit=1, enc_ready=1, frame_count=0, no tx_eof seen; new word afterwards transmits fully.
REQ-033 CLKS_PER_BIT=1, 256 back-to-back frames -> frame_count wraps to 0, tx_valid high 79 of every 80 cycles.
REQ-034 enc_valid pulsed during SHIFT and GAP -> ignored; frame contents and frame_count unchanged.
